// File: rtl/counter_sweep_driver.sv
// Command-side driver for the load/up/down counter: sweeps lo->hi->lo for a
// programmed number of passes and checks the counter output against a shadow count.
module counter_sweep_driver #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned PASS_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic [PASS_W-1:0] passes,
  input  logic [WIDTH-1:0]  count_in,
  output logic [1:0]        S,
  output logic [WIDTH-1:0]  datain,
  output logic              en,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              mismatch
);

  localparam logic [1:0] MODE_HOLD = 2'd0;
  localparam logic [1:0] MODE_UP   = 2'd1;
  localparam logic [1:0] MODE_DOWN = 2'd2;
  localparam logic [1:0] MODE_LOAD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_UP   = 3'd2,
    ST_DOWN = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [PASS_W-1:0]   passes_q, passes_d;
  logic [PASS_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic [WIDTH-1:0]    shadow_q, shadow_d;
  logic [1:0]          s_q, s_d;
  logic [WIDTH-1:0]    datain_q, datain_d;
  logic                en_q, en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cfg_err_q, cfg_err_d;
  logic                mismatch_q, mismatch_d;

  logic [WIDTH-1:0]    shadow_inc;
  logic [WIDTH-1:0]    shadow_dec;
  logic [PASS_W-1:0]   pass_cnt_inc;
  logic                sweeping;

  assign shadow_inc   = shadow_q + WIDTH'(1);
  assign shadow_dec   = shadow_q - WIDTH'(1);
  assign pass_cnt_inc = pass_cnt_q + PASS_W'(1);
  assign sweeping     = (state_q == ST_UP) || (state_q == ST_DOWN);

  // Sequencing, job capture and shadow-count tracking
  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    passes_d   = passes_q;
    pass_cnt_d = pass_cnt_q;
    shadow_d   = shadow_q;
    datain_d   = datain_q;
    cfg_err_d  = 1'b0;
    mismatch_d = mismatch_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (lo < hi) begin
            lo_d       = lo;
            hi_d       = hi;
            passes_d   = (passes == '0) ? PASS_W'(1) : passes;
            pass_cnt_d = '0;
            mismatch_d = 1'b0;
            datain_d   = lo;
            state_d    = ST_LOAD;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          shadow_d = lo_q;
          state_d  = ST_UP;
        end
      end
      ST_UP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          shadow_d = shadow_inc;
          if (shadow_inc == hi_q) begin
            state_d = ST_DOWN;
          end
        end
      end
      ST_DOWN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          shadow_d = shadow_dec;
          if (shadow_dec == lo_q) begin
            pass_cnt_d = pass_cnt_inc;
            state_d    = (pass_cnt_inc == passes_q) ? ST_DONE : ST_UP;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Counter feedback is only meaningful while it is actively sweeping
    if (sweeping && (count_in != shadow_q)) begin
      mismatch_d = 1'b1;
    end
  end

  // Outputs decoded from the next state so they are stable for the counter's sample
  always_comb begin
    s_d    = MODE_HOLD;
    en_d   = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      ST_LOAD: begin
        s_d    = MODE_LOAD;
        en_d   = 1'b1;
        busy_d = 1'b1;
      end
      ST_UP: begin
        s_d    = MODE_UP;
        en_d   = 1'b1;
        busy_d = 1'b1;
      end
      ST_DOWN: begin
        s_d    = MODE_DOWN;
        en_d   = 1'b1;
        busy_d = 1'b1;
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        s_d = MODE_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lo_q       <= '0;
      hi_q       <= '0;
      passes_q   <= '0;
      pass_cnt_q <= '0;
      shadow_q   <= '0;
      s_q        <= MODE_HOLD;
      datain_q   <= '0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      passes_q   <= passes_d;
      pass_cnt_q <= pass_cnt_d;
      shadow_q   <= shadow_d;
      s_q        <= s_d;
      datain_q   <= datain_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign S        = s_q;
  assign datain   = datain_q;
  assign en       = en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cfg_err  = cfg_err_q;
  assign mismatch = mismatch_q;

endmodule

// File: doc/counter_sweep_driver.md
Name: counter_sweep_driver

Overview:
- Command-side driver for the team's conditional load/up/down counter.
- Generates the counter's `S` mode code and `datain` load value, plus an enable (`en`) that connects to the counter's qualifying input.
- Each started job loads `lo`, counts up to `hi`, counts back down to `lo`, and repeats this for a programmed number of passes.
- Keeps a shadow copy of the expected count and checks it against the counter's `dataout`, which is fed back on `count_in`.

Parameters:
- WIDTH, 8, data width of `lo`, `hi`, `datain`, `count_in` and the shadow count.
- PASS_W, 4, width of the pass-count input.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; forces the reset state immediately.
- start  input  1  job request; sampled only in IDLE.
- abort  input  1  synchronous job cancel.
- lo  input  WIDTH  lower sweep limit, captured on start.
- hi  input  WIDTH  upper sweep limit, captured on start.
- passes  input  PASS_W  number of up/down passes, captured on start; 0 is treated as 1.
- count_in  input  WIDTH  counter `dataout` feedback.
- S  output  2  counter mode: 0 = hold/clear, 1 = up, 2 = down, 3 = load.
- datain  output  WIDTH  counter load value.
- en  output  1  counter enable (counter acts only when 1).
- busy  output  1  high from start acceptance until DONE.
- done  output  1  one-cycle pulse at job completion.
- cfg_err  output  1  one-cycle pulse when start is rejected.
- mismatch  output  1  sticky; set when `count_in` differs from the shadow count.

Behaviour:
- Reset (async, active-high): state = IDLE; S=0, datain=0, en=0, busy=0, done=0, cfg_err=0, mismatch=0, shadow=0, pass counter=0.
- All outputs are registered and decoded from the next state. They are therefore stable for the whole cycle in which the counter samples them.
- IDLE: S=0, en=0.
  - start=1 with lo<hi: capture lo/hi/passes, clear mismatch, set busy, go to LOAD.
  - start=1 with lo>=hi: pulse cfg_err for one cycle, stay IDLE, busy stays 0.
- LOAD (exactly 1 cycle): S=3, en=1, datain=lo. At the exit edge, shadow<=lo. Next state is UP.
- UP: S=1, en=1.
  - Every edge: shadow<=shadow+1.
  - On the edge where shadow+1==hi, go to DOWN.
  - UP therefore lasts exactly hi-lo cycles.
- DOWN: S=2, en=1.
  - Every edge: shadow<=shadow-1.
  - On the edge where shadow-1==lo, increment the pass counter. Then go to DONE if the pass counter reaches max(passes,1); otherwise go to UP.
  - DOWN lasts exactly hi-lo cycles.
- DONE (1 cycle): S=0, en=0, done=1, busy=0. Next state is IDLE.
- datain holds the captured lo from LOAD until the next accepted start. It is 0 after reset.
- Job latency: 1 + 2·(hi−lo)·max(passes,1) cycles from start acceptance to the DONE cycle.
- Mismatch check:
  - Active in UP and DOWN: if count_in != shadow, set mismatch (sticky).
  - Not checked in IDLE, LOAD or DONE.
  - Cleared only by reset or by an accepted start.
- Arithmetic is modulo 2^WIDTH. Wrap cannot occur inside a valid job because lo<hi is enforced.
- start while busy: ignored, with no cfg_err.
- abort=1 in LOAD/UP/DOWN: next state is IDLE with S=0, en=0, busy=0. No done pulse. Shadow and mismatch are retained.
- abort=1 in the same cycle as start in IDLE: abort wins and start is ignored.
- abort in DONE: DONE completes normally.
- Reset asserted mid-job: immediate return to the reset state. No done pulse.

Test Plan:
- Reset mid-UP, fed by a behavioural counter model:
  - Stimulus: reset=1 → 0, then start with lo=3, hi=6, passes=1. Assert reset during the 2nd UP cycle.
  - Response: outputs go to zero immediately and busy=0.
- Single pass, fed by the model counter:
  - Stimulus: restart with lo=3, hi=6, passes=1.
  - Response: S sequence is 3, 1,1,1, 2,2,2, then 0 with done=1.
  - count_in follows 3,4,5,6,5,4,3.
  - busy lasts 7 cycles; mismatch=0.
- Multiple passes:
  - Stimulus: lo=250, hi=255, passes=2.
  - Response: 21 busy cycles. Counter peaks at 255 twice and never wraps. Exactly one done pulse.
- passes=0:
  - Stimulus: lo=0, hi=1, passes=0.
  - Response: one pass (LOAD, UP, DOWN, DONE); done on the 4th cycle after start acceptance.
- Config error and start-while-busy:
  - Stimulus: start with lo=9, hi=9.
  - Response: cfg_err pulses once, busy stays 0.
  - Stimulus: start pulsed again during a running job.
  - Response: job is unaffected and there is no cfg_err.
- Abort and mismatch:
  - Stimulus: abort in the 3rd DOWN cycle.
  - Response: IDLE next cycle with S=0, en=0, no done.
  - Stimulus: a job in which the model counter sticks one value on the 2nd UP cycle.
  - Response: mismatch rises and stays 1 until the next accepted start.
